i2s_transmitter: RTL and testbench

Serializes 24-bit parallel audio samples into the I2S stream driven to the WM8731 DAC input (DACDAT), with the codec as master supplying BCLK and DACLRC. Sits between the playback/processing datapath and the codec pins, opposite the ADC-side I2S receiver. Accepts one stereo sample per frame through a valid/ready handshake with a one-deep holding buffer. Substitutes silence on underrun.

---
 rtl/i2s_transmitter.sv | 138 +++++++++++++
 tb/tb_i2s_transmitter.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_transmitter.sv
// I2S DACDAT serializer: 24-bit words in 32-BCLK slots, codec is BCLK/LRCLK master, all logic on BCLK fall.
// Optional macro I2S_TX_STEREO_EN adds i_right; without it the left word is sent in both slots.
`timescale 1ns/1ps
module i2s_transmitter (
    input  logic        bclk,
    input  logic        reset_n,
    input  logic        lrclk,
    input  logic [23:0] i_left,
`ifdef I2S_TX_STEREO_EN
    input  logic [23:0] i_right,
`endif
    input  logic        i_valid,
    output logic        o_ready,
    output logic        o_sdata,
    output logic        o_underrun
);

    logic        lrclk_q, lrclk_d;
    logic        primed_q, primed_d;
    logic        hold_full_q, hold_full_d;
    logic [23:0] hold_l_q, hold_l_d;
    logic [23:0] frame_l_q, frame_l_d;
    logic [23:0] shift_q, shift_d;
    logic [4:0]  bit_cnt_q, bit_cnt_d;
    logic        sdata_q, sdata_d;
    logic        underrun_q, underrun_d;
    logic        lrclk_edge, frame_start, accept;
    logic [23:0] right_word, slot_word;

    // The very first edge after reset only captures lrclk; transitions count once primed.
    assign lrclk_edge  = primed_q && (lrclk != lrclk_q);
    assign frame_start = lrclk_edge && !lrclk;
    assign accept      = i_valid && !hold_full_q;

    always_comb begin
        lrclk_d     = lrclk;
        primed_d    = 1'b1;
        hold_full_d = hold_full_q;
        hold_l_d    = hold_l_q;
        frame_l_d   = frame_l_q;
        underrun_d  = 1'b0;
        if (frame_start) begin
            if (hold_full_q) begin
                frame_l_d   = hold_l_q;
                hold_full_d = 1'b0;
            end else if (i_valid) begin
                frame_l_d   = i_left;
            end else begin
                frame_l_d   = '0;
                underrun_d  = 1'b1;
            end
        end else if (accept) begin
            hold_l_d    = i_left;
            hold_full_d = 1'b1;
        end
    end

`ifdef I2S_TX_STEREO_EN
    logic [23:0] hold_r_q, hold_r_d;
    logic [23:0] frame_r_q, frame_r_d;

    always_comb begin
        hold_r_d  = hold_r_q;
        frame_r_d = frame_r_q;
        if (frame_start) begin
            if (hold_full_q) begin
                frame_r_d = hold_r_q;
            end else if (i_valid) begin
                frame_r_d = i_right;
            end else begin
                frame_r_d = '0;
            end
        end else if (accept) begin
            hold_r_d = i_right;
        end
    end

    always_ff @(negedge bclk or negedge reset_n) begin
        if (!reset_n) begin
            hold_r_q  <= '0;
            frame_r_q <= '0;
        end else begin
            hold_r_q  <= hold_r_d;
            frame_r_q <= frame_r_d;
        end
    end

    assign right_word = frame_r_d;
`else
    assign right_word = frame_l_d;
`endif

    // MSB goes out on the detection edge itself, giving the standard one-bit I2S delay.
    always_comb begin
        slot_word = lrclk ? right_word : frame_l_d;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        sdata_d   = 1'b0;
        if (lrclk_edge) begin
            sdata_d   = slot_word[23];
            shift_d   = {slot_word[22:0], 1'b0};
            bit_cnt_d = 5'd1;
        end else if (bit_cnt_q < 5'd24) begin
            sdata_d   = shift_q[23];
            shift_d   = {shift_q[22:0], 1'b0};
            bit_cnt_d = bit_cnt_q + 5'd1;
        end
    end

    always_ff @(negedge bclk or negedge reset_n) begin
        if (!reset_n) begin
            lrclk_q     <= 1'b0;
            primed_q    <= 1'b0;
            hold_full_q <= 1'b0;
            hold_l_q    <= '0;
            frame_l_q   <= '0;
            shift_q     <= '0;
            bit_cnt_q   <= 5'd24;
            sdata_q     <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            lrclk_q     <= lrclk_d;
            primed_q    <= primed_d;
            hold_full_q <= hold_full_d;
            hold_l_q    <= hold_l_d;
            frame_l_q   <= frame_l_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            sdata_q     <= sdata_d;
            underrun_q  <= underrun_d;
        end
    end

    assign o_ready    = !hold_full_q;
    assign o_sdata    = sdata_q;
    assign o_underrun = underrun_q;

endmodule

// File: tb/tb_i2s_transmitter.sv
// Bench for i2s_transmitter: codec-style lrclk slots, frame vector table plus scoreboarded bit stream.
`timescale 1ns/1ps
module tb_i2s_transmitter;

`ifdef I2S_TX_STEREO_EN
    localparam bit STEREO = 1'b1;
`else
    localparam bit STEREO = 1'b0;
`endif

    typedef struct {
        logic        valid;
        logic [23:0] l;
        logic [23:0] r;
        logic [23:0] exp_l;
        logic [23:0] exp_r;
        int          urun;
    } vec_t;

    logic        bclk = 1'b0;
    logic        reset_n = 1'b0;
    logic        lrclk = 1'b0;
    logic        i_valid = 1'b0;
    logic [23:0] i_left = '0;
`ifdef I2S_TX_STEREO_EN
    logic [23:0] i_right = '0;
`endif
    logic        o_ready, o_sdata, o_underrun;

    int n_checks = 0;
    int n_fail = 0;

    // reference model state
    bit          m_primed;
    logic        m_lr;
    int          m_pos;
    logic [23:0] m_word, cur_l, cur_r;
    logic        m_urun;
    logic [47:0] hold_q[$];
    int          acc_cnt;
    bit          inc_mode;

    always #10 bclk = ~bclk;

    i2s_transmitter dut (
        .bclk      (bclk),
        .reset_n   (reset_n),
        .lrclk     (lrclk),
        .i_left    (i_left),
`ifdef I2S_TX_STEREO_EN
        .i_right   (i_right),
`endif
        .i_valid   (i_valid),
        .o_ready   (o_ready),
        .o_sdata   (o_sdata),
        .o_underrun(o_underrun)
    );

    function automatic logic [23:0] rval();
`ifdef I2S_TX_STEREO_EN
        return i_right;
`else
        return i_left;
`endif
    endfunction

    task automatic set_in(input logic [23:0] l, input logic [23:0] r);
        i_left = l;
`ifdef I2S_TX_STEREO_EN
        i_right = r;
`else
        if (r === 24'hx) i_left = l;
`endif
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_primed = 1'b0;
        m_lr     = 1'b0;
        m_pos    = 25;
        m_word   = '0;
        cur_l    = '0;
        cur_r    = '0;
        m_urun   = 1'b0;
        hold_q.delete();
    endtask

    // Called at negedge+1; drives one lrclk slot of n BCLKs, captures o_sdata on rising edges.
    task automatic run_slot(input string name, input logic lr, input int n, input bit offer,
                            output logic [31:0] cap, output int urun_seen);
        logic [31:0] expw;
        int          rdy_bad, urun_bad;
        logic        eb, edge_n, fs, took;
        cap = '0; expw = '0; rdy_bad = 0; urun_bad = 0; urun_seen = 0;
        lrclk = lr;
        if (offer) i_valid = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(posedge bclk); #1;
            eb = (m_pos >= 1 && m_pos <= 24) ? m_word[24-m_pos] : 1'b0;
            if (i < 32) begin
                cap[31-i]  = o_sdata;
                expw[31-i] = eb;
            end
            if (o_ready !== (hold_q.size() == 0)) rdy_bad++;
            if (o_underrun !== m_urun) urun_bad++;
            if (o_underrun === 1'b1) urun_seen++;
            edge_n = m_primed && (lrclk != m_lr);
            fs     = edge_n && !lrclk;
            took   = 1'b0;
            m_urun = 1'b0;
            if (fs) begin
                if (hold_q.size() != 0) begin
                    {cur_l, cur_r} = hold_q.pop_front();
                end else if (i_valid) begin
                    cur_l = i_left; cur_r = rval(); took = 1'b1;
                end else begin
                    cur_l = '0; cur_r = '0; m_urun = 1'b1;
                end
            end else if (i_valid && hold_q.size() == 0) begin
                hold_q.push_back({i_left, rval()});
                took = 1'b1;
            end
            if (took) acc_cnt++;
            if (edge_n) begin
                m_pos  = 1;
                m_word = lrclk ? cur_r : cur_l;
            end else if (m_pos <= 24) begin
                m_pos++;
            end
            m_primed = 1'b1;
            m_lr     = lrclk;
            @(negedge bclk); #1;
            if (took) begin
                if (inc_mode) begin
                    i_left = i_left + 24'd1;
`ifdef I2S_TX_STEREO_EN
                    i_right = i_right + 24'd1;
`endif
                end else begin
                    i_valid = 1'b0;
                end
            end
        end
        chk({name, "_bits"}, 64'(cap), 64'(expw));
        chk({name, "_ready"}, 64'(rdy_bad), 64'd0);
        chk({name, "_underrun"}, 64'(urun_bad), 64'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl[5];
        logic [31:0] cap;
        int          us, prev;
        bit          off;
        logic [23:0] rw, w;

        tbl[0] = '{1'b1, 24'h800001, 24'h7FFFFE, 24'h800001, STEREO ? 24'h7FFFFE : 24'h800001, 0};
        tbl[1] = '{1'b0, 24'h111111, 24'h222222, 24'h000000, 24'h000000, 1};
        tbl[2] = '{1'b0, 24'h000000, 24'h000000, 24'h000000, 24'h000000, 1};
        tbl[3] = '{1'b1, 24'hC35A0F, 24'h0F0F0F, 24'hC35A0F, STEREO ? 24'h0F0F0F : 24'hC35A0F, 0};
        tbl[4] = '{1'b1, 24'hFFFFFF, 24'h000001, 24'hFFFFFF, STEREO ? 24'h000001 : 24'hFFFFFF, 0};

        inc_mode = 1'b0;
        acc_cnt  = 0;
        model_reset();
        repeat (3) @(negedge bclk);
        #1;
        chk("reset_sdata", 64'(o_sdata), 64'd0);
        chk("reset_ready", 64'(o_ready), 64'd1);
        chk("reset_underrun", 64'(o_underrun), 64'd0);

        // Frame table: each entry is offered in the preceding right slot and plays in its own frame.
        set_in(tbl[0].l, tbl[0].r);
        reset_n = 1'b1;
        run_slot("pre_r", 1'b1, 32, tbl[0].valid, cap, us);
        for (int i = 0; i < 5; i++) begin
            run_slot("vec_l", 1'b0, 32, 1'b0, cap, us);
            chk($sformatf("vec%0d_left", i), 64'(cap), 64'({1'b0, tbl[i].exp_l, 7'd0}));
            chk($sformatf("vec%0d_urun", i), 64'(us), 64'(tbl[i].urun));
            off = 1'b0;
            if (i < 4) begin
                set_in(tbl[i+1].l, tbl[i+1].r);
                off = tbl[i+1].valid;
            end
            run_slot("vec_r", 1'b1, 32, off, cap, us);
            chk($sformatf("vec%0d_right", i), 64'(cap), 64'({1'b0, tbl[i].exp_r, 7'd0}));
        end

        // i_valid held high with incrementing data: one accept per frame, no skip or repeat.
        run_slot("inc_pre_l", 1'b0, 32, 1'b0, cap, us);
        inc_mode = 1'b1;
        set_in(24'h000100, 24'h800100);
        run_slot("inc_pre_r", 1'b1, 32, 1'b1, cap, us);
        for (int k = 0; k < 3; k++) begin
            prev = acc_cnt;
            run_slot("inc_l", 1'b0, 32, 1'b0, cap, us);
            w = 24'h000100 + 24'(k);
            chk($sformatf("inc%0d_left", k), 64'(cap), 64'({1'b0, w, 7'd0}));
            run_slot("inc_r", 1'b1, 32, 1'b0, cap, us);
            w = STEREO ? (24'h800100 + 24'(k)) : (24'h000100 + 24'(k));
            chk($sformatf("inc%0d_right", k), 64'(cap), 64'({1'b0, w, 7'd0}));
            chk($sformatf("inc%0d_accepts", k), 64'(acc_cnt - prev), 64'd1);
        end
        inc_mode = 1'b0;
        i_valid  = 1'b0;
        run_slot("inc_last_l", 1'b0, 32, 1'b0, cap, us);
        chk("inc_last_left", 64'(cap), 64'({1'b0, 24'h000103, 7'd0}));
        run_slot("inc_last_r", 1'b1, 32, 1'b0, cap, us);

        // Bypass: i_valid rises on the frame-start edge with the buffer empty.
        set_in(24'h5A5A5A, 24'hA5A5A5);
        run_slot("byp_l", 1'b0, 32, 1'b1, cap, us);
        chk("byp_left", 64'(cap), 64'({1'b0, 24'h5A5A5A, 7'd0}));
        chk("byp_urun", 64'(us), 64'd0);

        // Short 16-BCLK right slot truncates the word; next left slot starts cleanly.
        rw = STEREO ? 24'hA5A5A5 : 24'h5A5A5A;
        set_in(24'hC00003, 24'h3000C0);
        run_slot("short_r", 1'b1, 16, 1'b1, cap, us);
        chk("short_right_head", 64'(cap[31:16]), 64'({1'b0, rw[23:9]}));
        run_slot("after_short_l", 1'b0, 32, 1'b0, cap, us);
        chk("after_short_left", 64'(cap), 64'({rw[8], 24'hC00003, 7'd0}));
        set_in(24'h654321, 24'h111111);
        run_slot("after_short_r", 1'b1, 32, 1'b1, cap, us);
        w = STEREO ? 24'h3000C0 : 24'hC00003;
        chk("after_short_right", 64'(cap), 64'({1'b0, w, 7'd0}));

        // Reset mid-left-word with the buffer full, release with lrclk high.
        set_in(24'hFFFFFF, 24'hFFFFFF);
        run_slot("rst_l", 1'b0, 10, 1'b1, cap, us);
        w = 24'h654321;
        chk("rst_pre_sdata", 64'(o_sdata), 64'(w[14]));
        chk("rst_pre_ready", 64'(o_ready), 64'd0);
        reset_n = 1'b0;
        #1;
        chk("rst_sdata", 64'(o_sdata), 64'd0);
        chk("rst_ready", 64'(o_ready), 64'd1);
        chk("rst_underrun", 64'(o_underrun), 64'd0);
        model_reset();
        i_valid = 1'b0;
        @(negedge bclk); #1;
        @(negedge bclk); #1;
        lrclk = 1'b1;
        set_in(24'h123456, 24'h0FEDCB);
        reset_n = 1'b1;
        run_slot("rel_r", 1'b1, 32, 1'b1, cap, us);
        chk("rel_idle_right", 64'(cap), 64'd0);
        run_slot("rel_l", 1'b0, 32, 1'b0, cap, us);
        chk("rel_left", 64'(cap), 64'({1'b0, 24'h123456, 7'd0}));
        chk("rel_urun", 64'(us), 64'd0);
        run_slot("rel_r2", 1'b1, 32, 1'b0, cap, us);
        w = STEREO ? 24'h0FEDCB : 24'h123456;
        chk("rel_right", 64'(cap), 64'({1'b0, w, 7'd0}));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
